// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a FIFO built around a 2-port RAM.
// Generates RAM write/read enables and addresses plus full/empty/count status.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0]   DEPTH    = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH);
  assign w_addr = wptr_q;
  assign r_addr = rptr_q;
  assign count  = count_q;

  // Enables are gated by reset so the RAM never sees a write/read while clearing.
  assign wr_en = wr & ~full & ~reset;
  assign rd_en = rd & ~empty & ~reset;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + PTR_ONE;
    if (rd_en) rptr_d = rptr_q + PTR_ONE;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a queue-based model plus an attached RAM
// whose read data is scoreboarded against the order of accepted pushes.
module tb_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          wr_en, rd_en, empty, full;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   count;

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd),
    .wr_en(wr_en), .rd_en(rd_en), .w_addr(w_addr), .r_addr(r_addr),
    .empty(empty), .full(full), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM attached to the controller
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] r_data = '0;
  always @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
    if (rd_en) r_data <= mem[r_addr];
  end

  // behavioural model: occupancy is the queue size, pointers are totals mod depth
  logic [DW-1:0] exp_q[$];
  int unsigned   n_push = 0;
  int unsigned   n_pop  = 0;
  logic [DW-1:0] pend_data;
  bit            pend_valid = 0;
  bit            check_en = 0;
  int            tests = 0;
  int            fails = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      n_push = 0;
      n_pop = 0;
      pend_valid = 0;
    end else begin
      bit acc_w, acc_r;
      acc_w = wr && (exp_q.size() < DEPTH);
      acc_r = rd && (exp_q.size() > 0);
      pend_valid = 0;
      if (acc_r) begin
        pend_data = exp_q.pop_front();
        pend_valid = 1;
        n_pop++;
      end
      if (acc_w) begin
        exp_q.push_back(w_data);
        n_push++;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // compare process: every negedge, outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      int occ;
      occ = reset ? 0 : exp_q.size();
      check("count",  count,  occ);
      check("empty",  empty,  occ == 0);
      check("full",   full,   occ == DEPTH);
      check("w_addr", w_addr, reset ? 0 : n_push % DEPTH);
      check("r_addr", r_addr, reset ? 0 : n_pop % DEPTH);
      check("wr_en",  wr_en,  !reset && wr && occ < DEPTH);
      check("rd_en",  rd_en,  !reset && rd && occ > 0);
      if (pend_valid && !reset) begin
        check("r_data", r_data, pend_data);
        pend_valid = 0;
      end
    end
  end

  // driver tasks
  task automatic cyc(input bit w, input bit r);
    @(posedge clk);
    #1;
    wr = w;
    rd = r;
    w_data = DW'($urandom);
  endtask

  task automatic repeat_cyc(input int n, input bit w, input bit r);
    for (int i = 0; i < n; i++) cyc(w, r);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    wr = 0;
    rd = 0;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    #23;
    reset = 0;
    check_en = 1;
    @(negedge clk);
    check("reset count", count, 0);
    check("reset empty", empty, 1);

    // async reset mid-cycle after three pushes
    repeat_cyc(3, 1, 0);
    cyc(0, 0);
    #2;
    check("pre-reset count", count, 3);
    reset = 1;
    #1;
    check("async count",  count, 0);
    check("async empty",  empty, 1);
    check("async full",   full, 0);
    check("async w_addr", w_addr, 0);
    check("async r_addr", r_addr, 0);
    cyc(0, 0);
    reset = 0;

    // fill: 17 cycles of wr
    repeat_cyc(17, 1, 0);
    @(negedge clk);
    check("fill count",  count, 16);
    check("fill full",   full, 1);
    check("fill wr_en",  wr_en, 0);
    check("fill w_addr", w_addr, 0);
    check("model full",  exp_q.size(), 16);

    // drain: 17 cycles of rd
    repeat_cyc(17, 0, 1);
    @(negedge clk);
    check("drain empty",  empty, 1);
    check("drain rd_en",  rd_en, 0);
    check("drain r_addr", r_addr, 0);

    // wrap: push 10, pop 10, push 10
    do_reset();
    repeat_cyc(10, 1, 0);
    repeat_cyc(10, 0, 1);
    repeat_cyc(10, 1, 0);
    cyc(0, 0);
    @(negedge clk);
    check("wrap w_addr", w_addr, 4);
    check("wrap r_addr", r_addr, 10);
    check("wrap count",  count, 10);
    check("wrap flags",  {empty, full}, 0);
    check("model wrap",  n_push % DEPTH, 4);

    // count 5, simultaneous push/pop for 4 cycles
    repeat_cyc(5, 0, 1);
    cyc(1, 1);
    @(negedge clk);
    check("both en", {wr_en, rd_en}, 3);
    repeat_cyc(3, 1, 1);
    cyc(0, 0);
    @(negedge clk);
    check("both count",  count, 5);
    check("both w_addr", w_addr, 8);
    check("both r_addr", r_addr, 3);

    // simultaneous when empty, then when full
    repeat_cyc(5, 0, 1);
    cyc(1, 1);
    @(negedge clk);
    check("empty both wr_en", wr_en, 1);
    check("empty both rd_en", rd_en, 0);
    cyc(0, 0);
    @(negedge clk);
    check("empty both count", count, 1);
    repeat_cyc(15, 1, 0);
    cyc(1, 1);
    @(negedge clk);
    check("full both rd_en", rd_en, 1);
    check("full both wr_en", wr_en, 0);
    cyc(0, 0);
    @(negedge clk);
    check("full both count", count, 15);

    // randomized traffic with biased phases and rare resets
    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 200) % 3;
      @(posedge clk);
      #1;
      case (mode)
        0: begin wr = ($urandom_range(0, 9) < 8); rd = ($urandom_range(0, 9) < 3); end
        1: begin wr = ($urandom_range(0, 9) < 3); rd = ($urandom_range(0, 9) < 8); end
        default: begin wr = $urandom_range(0, 1); rd = $urandom_range(0, 1); end
      endcase
      w_data = DW'($urandom);
      reset = ($urandom_range(0, 399) == 0);
    end
    cyc(0, 0);
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
